// File: rtl/adam_axil_obi_pkg.sv
// -----------------------------------------------------------------------------
// adam_axil_obi_pkg
// Shared declarations for the AXI-Lite to OBI bridge:
//   - state_e     : bridge FSM state encoding
//   - RESP_OKAY   : AXI response code for a good transfer
//   - RESP_SLVERR : AXI response code for a slave-side error
// -----------------------------------------------------------------------------
package adam_axil_obi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        RESP   = 3'd2,
        AXI_B  = 3'd3,
        AXI_R  = 3'd4,
        PAUSED = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/adam_axil_obi_bridge.sv
// -----------------------------------------------------------------------------
// adam_axil_obi_bridge
// Converts AXI-Lite slave traffic into OBI master transactions, one at a time.
// AW and W are held independently until both are present; AR is taken directly
// in IDLE. When a write and a read are eligible in the same cycle, a
// round-robin flag picks the side that did not win the previous tie.
// A pause request lets the in-flight transfer finish, then parks the bridge in
// PAUSED with pause_ack high until the request drops.
//
// Optional feature: define ADAM_AXIL_OBI_ERR_EN to report OBI err as SLVERR on
// B/R. Without it err is ignored and every response is OKAY.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_pause_req / o_pause_ack       pause handshake
//   i_aw_* / o_aw_ready             AXI write address channel
//   i_w_*  / o_w_ready              AXI write data channel
//   o_b_*  / i_b_ready              AXI write response channel
//   i_ar_* / o_ar_ready             AXI read address channel
//   o_r_*  / i_r_ready              AXI read data channel
//   o_req, i_gnt, o_addr, o_we, o_be, o_wdata   OBI request channel
//   i_rvalid, o_rready, i_rdata, i_err          OBI response channel
// -----------------------------------------------------------------------------
module adam_axil_obi_bridge
    import adam_axil_obi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    i_pause_req,
    output logic                    o_pause_ack,

    input  logic                    i_aw_valid,
    output logic                    o_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   i_aw_addr,

    input  logic                    i_w_valid,
    output logic                    o_w_ready,
    input  logic [DATA_WIDTH-1:0]   i_w_data,
    input  logic [DATA_WIDTH/8-1:0] i_w_strb,

    output logic                    o_b_valid,
    input  logic                    i_b_ready,
    output logic [1:0]              o_b_resp,

    input  logic                    i_ar_valid,
    output logic                    o_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ar_addr,

    output logic                    o_r_valid,
    input  logic                    i_r_ready,
    output logic [DATA_WIDTH-1:0]   o_r_data,
    output logic [1:0]              o_r_resp,

    output logic                    o_req,
    input  logic                    i_gnt,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic                    o_we,
    output logic [DATA_WIDTH/8-1:0] o_be,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    i_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_e                  r_state,     w_state_next;
    // AXI holding registers
    logic                    r_aw_full,   w_aw_full_next;
    logic [ADDR_WIDTH-1:0]   r_aw_addr,   w_aw_addr_next;
    logic                    r_w_full,    w_w_full_next;
    logic [DATA_WIDTH-1:0]   r_w_data,    w_w_data_next;
    logic [STRB_WIDTH-1:0]   r_w_strb,    w_w_strb_next;
    logic                    r_ar_pend,   w_ar_pend_next;
    logic [ADDR_WIDTH-1:0]   r_ar_addr,   w_ar_addr_next;
    logic                    r_last_read, w_last_read_next;
    // Registered AXI outputs
    logic                    r_aw_ready,  w_aw_ready_next;
    logic                    r_w_ready,   w_w_ready_next;
    logic                    r_ar_ready,  w_ar_ready_next;
    logic                    r_b_valid,   w_b_valid_next;
    logic                    r_r_valid,   w_r_valid_next;
    logic [DATA_WIDTH-1:0]   r_r_data,    w_r_data_next;
    logic [1:0]              r_resp,      w_resp_next;
    logic                    r_pause_ack, w_pause_ack_next;
    // Registered OBI outputs
    logic                    r_req,       w_req_next;
    logic [ADDR_WIDTH-1:0]   r_addr,      w_addr_next;
    logic                    r_we,        w_we_next;
    logic [STRB_WIDTH-1:0]   r_be,        w_be_next;
    logic [DATA_WIDTH-1:0]   r_wdata,     w_wdata_next;
    logic                    r_rready,    w_rready_next;

    logic w_aw_hs, w_w_hs, w_ar_hs;
    logic w_wr_elig, w_rd_elig, w_pick_write;
    logic w_err_flag;

`ifdef ADAM_AXIL_OBI_ERR_EN
    assign w_err_flag = i_err;
`else
    logic w_unused_err;
    assign w_unused_err = i_err;
    assign w_err_flag   = 1'b0;
`endif

    assign w_aw_hs = r_aw_ready & i_aw_valid;
    assign w_w_hs  = r_w_ready  & i_w_valid;
    assign w_ar_hs = r_ar_ready & i_ar_valid;

    always_comb begin
        w_state_next     = r_state;
        w_aw_full_next   = r_aw_full;
        w_aw_addr_next   = r_aw_addr;
        w_w_full_next    = r_w_full;
        w_w_data_next    = r_w_data;
        w_w_strb_next    = r_w_strb;
        w_ar_pend_next   = r_ar_pend;
        w_ar_addr_next   = r_ar_addr;
        w_last_read_next = r_last_read;
        w_r_data_next    = r_r_data;
        w_resp_next      = r_resp;
        w_req_next       = r_req;
        w_addr_next      = r_addr;
        w_we_next        = r_we;
        w_be_next        = r_be;
        w_wdata_next     = r_wdata;
        w_wr_elig        = 1'b0;
        w_rd_elig        = 1'b0;
        w_pick_write     = 1'b0;

        if (w_aw_hs) begin
            w_aw_full_next = 1'b1;
            w_aw_addr_next = i_aw_addr;
        end
        if (w_w_hs) begin
            w_w_full_next = 1'b1;
            w_w_data_next = i_w_data;
            w_w_strb_next = i_w_strb;
        end
        if (w_ar_hs) begin
            w_ar_addr_next = i_ar_addr;
        end

        case (r_state)
            IDLE: begin
                w_wr_elig = r_aw_full & r_w_full;
                w_rd_elig = w_ar_hs | r_ar_pend;
                // The flag only moves on a genuine tie, so a read that was
                // parked behind a write does not count as a win for reads.
                if (w_wr_elig && w_rd_elig) begin
                    w_pick_write     = r_last_read;
                    w_last_read_next = ~r_last_read;
                end else begin
                    w_pick_write     = w_wr_elig;
                end

                if (w_wr_elig || w_rd_elig) begin
                    w_state_next = REQ;
                    w_req_next   = 1'b1;
                    if (w_pick_write) begin
                        w_we_next    = 1'b1;
                        w_addr_next  = r_aw_addr;
                        w_be_next    = r_w_strb;
                        w_wdata_next = r_w_data;
                        // An AR accepted in the same cycle waits its turn.
                        if (w_ar_hs) begin
                            w_ar_pend_next = 1'b1;
                        end
                    end else begin
                        w_we_next      = 1'b0;
                        w_addr_next    = w_ar_hs ? i_ar_addr : r_ar_addr;
                        w_be_next      = '1;
                        w_wdata_next   = '0;
                        w_ar_pend_next = 1'b0;
                    end
                end else if (i_pause_req) begin
                    w_state_next = PAUSED;
                end
            end

            REQ: begin
                if (i_gnt) begin
                    w_req_next = 1'b0;
                    // Response may arrive together with the grant.
                    if (i_rvalid) begin
                        w_r_data_next = i_rdata;
                        w_resp_next   = w_err_flag ? RESP_SLVERR : RESP_OKAY;
                        w_state_next  = r_we ? AXI_B : AXI_R;
                    end else begin
                        w_state_next  = RESP;
                    end
                end
            end

            RESP: begin
                if (i_rvalid) begin
                    w_r_data_next = i_rdata;
                    w_resp_next   = w_err_flag ? RESP_SLVERR : RESP_OKAY;
                    w_state_next  = r_we ? AXI_B : AXI_R;
                end
            end

            AXI_B: begin
                if (i_b_ready) begin
                    w_state_next   = IDLE;
                    w_aw_full_next = 1'b0;
                    w_w_full_next  = 1'b0;
                end
            end

            AXI_R: begin
                if (i_r_ready) begin
                    w_state_next = IDLE;
                end
            end

            PAUSED: begin
                if (!i_pause_req) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        // All handshake outputs follow the state the FSM is about to enter.
        w_rready_next    = (w_state_next == RESP);
        w_b_valid_next   = (w_state_next == AXI_B);
        w_r_valid_next   = (w_state_next == AXI_R);
        w_pause_ack_next = (w_state_next == PAUSED);
        w_aw_ready_next  = !w_aw_full_next && (w_state_next != PAUSED) && !i_pause_req;
        w_w_ready_next   = !w_w_full_next  && (w_state_next != PAUSED) && !i_pause_req;
        w_ar_ready_next  = (w_state_next == IDLE) && !i_pause_req && !w_ar_pend_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_aw_full   <= 1'b0;
            r_aw_addr   <= '0;
            r_w_full    <= 1'b0;
            r_w_data    <= '0;
            r_w_strb    <= '0;
            r_ar_pend   <= 1'b0;
            r_ar_addr   <= '0;
            r_last_read <= 1'b1;
            r_aw_ready  <= 1'b0;
            r_w_ready   <= 1'b0;
            r_ar_ready  <= 1'b0;
            r_b_valid   <= 1'b0;
            r_r_valid   <= 1'b0;
            r_r_data    <= '0;
            r_resp      <= RESP_OKAY;
            r_pause_ack <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_rready    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_aw_full   <= w_aw_full_next;
            r_aw_addr   <= w_aw_addr_next;
            r_w_full    <= w_w_full_next;
            r_w_data    <= w_w_data_next;
            r_w_strb    <= w_w_strb_next;
            r_ar_pend   <= w_ar_pend_next;
            r_ar_addr   <= w_ar_addr_next;
            r_last_read <= w_last_read_next;
            r_aw_ready  <= w_aw_ready_next;
            r_w_ready   <= w_w_ready_next;
            r_ar_ready  <= w_ar_ready_next;
            r_b_valid   <= w_b_valid_next;
            r_r_valid   <= w_r_valid_next;
            r_r_data    <= w_r_data_next;
            r_resp      <= w_resp_next;
            r_pause_ack <= w_pause_ack_next;
            r_req       <= w_req_next;
            r_addr      <= w_addr_next;
            r_we        <= w_we_next;
            r_be        <= w_be_next;
            r_wdata     <= w_wdata_next;
            r_rready    <= w_rready_next;
        end
    end

    assign o_pause_ack = r_pause_ack;
    assign o_aw_ready  = r_aw_ready;
    assign o_w_ready   = r_w_ready;
    assign o_ar_ready  = r_ar_ready;
    assign o_b_valid   = r_b_valid;
    assign o_b_resp    = r_resp;
    assign o_r_valid   = r_r_valid;
    assign o_r_data    = r_r_data;
    assign o_r_resp    = r_resp;
    assign o_req       = r_req;
    assign o_addr      = r_addr;
    assign o_we        = r_we;
    assign o_be        = r_be;
    assign o_wdata     = r_wdata;
    assign o_rready    = r_rready;

endmodule

// File: doc/adam_axil_obi_bridge.md
ADAM_AXIL_OBI_BRIDGE -- requirements
Module: adam_axil_obi_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, address width of both sides.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width of both sides; STRB_WIDTH = DATA_WIDTH/8 is derived and not overridable.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pause  ADAM_PAUSE.Slave  -  pause request in, pause acknowledge out.
REQ-006 axil  AXI_LITE.Slave  -  AW/W/B/AR/R channels from the fabric.
REQ-007 req  output  1  OBI request; gnt  input  1  OBI grant.
REQ-008 addr  output  ADDR_WIDTH  OBI address.
REQ-009 we  output  1  OBI write enable.
REQ-010 be  output  STRB_WIDTH  OBI byte enables.
REQ-011 wdata  output  DATA_WIDTH  OBI write data.
REQ-012 rvalid  input  1  OBI response valid; rready  output  1  OBI response ready.
REQ-013 rdata  input  DATA_WIDTH  OBI read data; err  input  1  OBI error flag.

Function
REQ-014 The block SHALL run FSM states IDLE, REQ, RESP, AXI_B, AXI_R, PAUSED; all outputs registered.
REQ-015 AW and W SHALL be captured independently into holding registers; aw_ready and w_ready SHALL be high only when the respective holding register is empty and the FSM is not pausing.
REQ-016 ar_ready SHALL be high only in IDLE with no pending pause request; one outstanding transaction at a time.
REQ-017 In IDLE, a write SHALL be eligible when both AW and W are held; a read when AR handshakes; on both eligible, round-robin arbitration, last-served flag resets to "read", so write wins first.
REQ-018 REQ: req=1 with addr/we/be/wdata stable until gnt=1; reads drive be all-ones and we=0.
REQ-019 RESP: rready=1; on rvalid=1, capture rdata and err, go to AXI_R (read) or AXI_B (write).
REQ-020 AXI_B: b_valid=1 until b_ready; AXI_R: r_valid=1 with captured data until r_ready; then IDLE, write holding registers cleared after B handshake.
REQ-021 Minimum read latency: AR handshake cycle 0, req cycle 1 (gnt same cycle), rvalid cycle 2, r_valid cycle 3.
REQ-022 gnt and rvalid in the same cycle SHALL be accepted (REQ to AXI_R/AXI_B directly).
REQ-023 pause.req=1: finish any in-flight transaction, then enter PAUSED with pause.ack=1; no new AXI handshakes while paused.
REQ-024 pause.req=0 in PAUSED: drop pause.ack next cycle, return IDLE; held AW/W contents SHALL survive pause.
REQ-025 Address/data SHALL pass unmodified; no alignment checking.

Reset
REQ-026 On rst_n=0, asynchronously: state IDLE, req=0, rready=0, all AXI valid/ready outputs 0, pause.ack=0, holding registers empty, data registers 0.
REQ-027 Reset mid-transaction SHALL abandon it with no AXI response issued.

Configuration
REQ-028 With ADAM_AXIL_OBI_ERR_EN defined, captured err=1 SHALL yield resp=2'b10 (SLVERR) on B or R; without it, err is ignored and resp is always 2'b00 (OKAY).

Structure
REQ-029 FSM state typedef and response constants RESP_OKAY/RESP_SLVERR SHALL live in shared package adam_axil_obi_pkg.
REQ-030 No sub-module; arbitration and holding registers stay inline.

Verification
REQ-031 Read 0x0000_1000, slave gnt immediate, rvalid next cycle with rdata=0xDEAD_BEEF -> R 0xDEAD_BEEF OKAY, r_valid at cycle 3.
REQ-032 W (0x1234_5678, strb 0x3) two cycles before AW 0x20 -> one OBI write, we=1, be=0x3, then single B OKAY.
REQ-033 Simultaneous write and read from reset -> write issued first, then read; next tie -> read first.
REQ-034 gnt withheld 5 cycles -> addr/we/be/wdata stable throughout, req held.
REQ-035 err=1 on read -> SLVERR with macro defined, OKAY without.
REQ-036 pause.req during RESP -> response completes, then pause.ack=1, AR ignored; release -> ack=0 next cycle, AR accepted.
